// File: rtl/bcd_time_counter_pkg.sv
// Shared constants and helpers for the HH:MM:SS BCD time counter.
// Digit slice positions, field limits, 2-digit BCD increment.
package bcd_time_counter_pkg;

  localparam int S0_LSB = 0;
  localparam int S1_LSB = 4;
  localparam int M0_LSB = 8;
  localparam int M1_LSB = 12;
  localparam int H0_LSB = 16;
  localparam int H1_LSB = 20;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;

  // Next value of a 2-digit BCD field that wraps to 00 after max.
  function automatic logic [7:0] bcd2_inc(
    input logic [7:0] v,
    input logic [7:0] max
  );
    logic [7:0] r;
    if (v == max) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// 2-digit BCD counter wrapping after MAX, with sync clear.
// Ports: clk, reset, inc, clr in; value[7:0], carry (wrap on inc) out.
module bcd_mod_counter
  import bcd_time_counter_pkg::*;
#(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] value,
  output logic       carry
);

  logic [7:0] value_q;
  logic [7:0] value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = 8'h00;
    end else if (inc) begin
      value_d = bcd2_inc(value_q, MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= 8'h00;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign carry = inc && !clr && (value_q == MAX);

endmodule

// File: rtl/bcd_time_counter.sv
// 24-hour HH:MM:SS BCD time-of-day counter with 1 Hz prescaler.
// Ports: clk, reset, run, inc_min, inc_hour, clr_sec in; counter[23:0], sec_tick out.
module bcd_time_counter
  import bcd_time_counter_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int PS_W     = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        inc_min,
  input  logic        inc_hour,
  input  logic        clr_sec,
  output logic [23:0] counter,
  output logic        sec_tick
);

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  logic [PS_W-1:0] ps_q;
  logic [PS_W-1:0] ps_d;
  logic            sec_tick_q;

  logic       tick_raw;
  logic       inc_any;
  logic       tick;
  logic [7:0] sec_v;
  logic [7:0] min_v;
  logic [7:0] hour_v;
  logic       sec_carry;
  logic       min_carry;
  logic       unused_day_wrap;

  assign tick_raw = run && (ps_q == PS_LAST);
  assign inc_any  = inc_min || inc_hour;
  // A tick colliding with a manual set or a seconds clear is not applied.
  assign tick     = tick_raw && !clr_sec && !inc_any;

  always_comb begin
    ps_d = ps_q;
    if (clr_sec) begin
      ps_d = '0;
    end else if (run) begin
      if (tick_raw) begin
        // Hold at the last count so the deferred tick fires next cycle.
        if (!inc_any) begin
          ps_d = '0;
        end
      end else begin
        ps_d = ps_q + PS_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ps_q       <= '0;
      sec_tick_q <= 1'b0;
    end else begin
      ps_q       <= ps_d;
      sec_tick_q <= tick;
    end
  end

  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk  (clk),
    .reset(reset),
    .inc  (tick),
    .clr  (clr_sec),
    .value(sec_v),
    .carry(sec_carry)
  );

  // Manual minute steps must not ripple into hours, so only a
  // tick-driven minute wrap carries.
  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk  (clk),
    .reset(reset),
    .inc  (inc_min || sec_carry),
    .clr  (1'b0),
    .value(min_v),
    .carry(min_carry)
  );

  bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
    .clk  (clk),
    .reset(reset),
    .inc  (inc_hour || (min_carry && tick)),
    .clr  (1'b0),
    .value(hour_v),
    .carry(unused_day_wrap)
  );

  assign counter[S0_LSB +: 4] = sec_v[3:0];
  assign counter[S1_LSB +: 4] = sec_v[7:4];
  assign counter[M0_LSB +: 4] = min_v[3:0];
  assign counter[M1_LSB +: 4] = min_v[7:4];
  assign counter[H0_LSB +: 4] = hour_v[3:0];
  assign counter[H1_LSB +: 4] = hour_v[7:4];
  assign sec_tick = sec_tick_q;

endmodule
